// File: rtl/axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rr_arbiter
//   N-to-1 AXI4-Lite arbiter. Core-side requesters (master 0 = IFU,
//   master 1 = LSU, higher indices for DMA/debug) share one downstream
//   AXI slave port. The read path (AR/R) and the write path (AW/W/B) are
//   arbitrated independently, each with a round-robin pointer. A grant is
//   held from the request until the response handshake completes.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   slv_ar_* / slv_r_*      per-master read channels (R data/resp broadcast)
//   slv_aw_* / slv_w_*      per-master write address/data channels
//   slv_b_*                 per-master write response (resp broadcast)
//   mst_ar_* / mst_r_*      downstream read channels
//   mst_aw_* / mst_w_*      downstream write address/data channels
//   mst_b_*                 downstream write response
//
// Per-master address/data buses are flat: master k occupies slice k of the
// vector ([k*ADDR_W +: ADDR_W], etc.).
// ---------------------------------------------------------------------------
module axi_rr_arbiter #(
  parameter  int NUM_MST = 3,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int STRB_W  = DATA_W / 8,
  localparam int IDX_W   = $clog2(NUM_MST)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // upstream read
  input  logic [NUM_MST-1:0]         slv_ar_valid_i,
  input  logic [NUM_MST*ADDR_W-1:0]  slv_ar_addr_i,
  output logic [NUM_MST-1:0]         slv_ar_ready_o,
  output logic [NUM_MST-1:0]         slv_r_valid_o,
  output logic [DATA_W-1:0]          slv_r_data_o,
  output logic [1:0]                 slv_r_resp_o,
  input  logic [NUM_MST-1:0]         slv_r_ready_i,
  // upstream write
  input  logic [NUM_MST-1:0]         slv_aw_valid_i,
  input  logic [NUM_MST*ADDR_W-1:0]  slv_aw_addr_i,
  output logic [NUM_MST-1:0]         slv_aw_ready_o,
  input  logic [NUM_MST-1:0]         slv_w_valid_i,
  input  logic [NUM_MST*DATA_W-1:0]  slv_w_data_i,
  input  logic [NUM_MST*STRB_W-1:0]  slv_w_strb_i,
  output logic [NUM_MST-1:0]         slv_w_ready_o,
  output logic [NUM_MST-1:0]         slv_b_valid_o,
  output logic [1:0]                 slv_b_resp_o,
  input  logic [NUM_MST-1:0]         slv_b_ready_i,
  // downstream read
  output logic                       mst_ar_valid_o,
  output logic [ADDR_W-1:0]          mst_ar_addr_o,
  input  logic                       mst_ar_ready_i,
  input  logic                       mst_r_valid_i,
  input  logic [DATA_W-1:0]          mst_r_data_i,
  input  logic [1:0]                 mst_r_resp_i,
  output logic                       mst_r_ready_o,
  // downstream write
  output logic                       mst_aw_valid_o,
  output logic [ADDR_W-1:0]          mst_aw_addr_o,
  input  logic                       mst_aw_ready_i,
  output logic                       mst_w_valid_o,
  output logic [DATA_W-1:0]          mst_w_data_o,
  output logic [STRB_W-1:0]          mst_w_strb_o,
  input  logic                       mst_w_ready_i,
  input  logic                       mst_b_valid_i,
  input  logic [1:0]                 mst_b_resp_i,
  output logic                       mst_b_ready_o
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP}  wr_state_t;

  // Round-robin search: first asserted request at or after ptr, wrapping.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int i = 0; i < NUM_MST; i++) begin
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = (idx == IDX_W'(NUM_MST-1)) ? '0 : idx + 1'b1;
    end
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    next_idx = (g == IDX_W'(NUM_MST-1)) ? '0 : g + 1'b1;
  endfunction

  // Flat buses viewed as per-master arrays for grant-indexed muxing.
  logic [NUM_MST-1:0][ADDR_W-1:0] w_ar_addr_arr;
  logic [NUM_MST-1:0][ADDR_W-1:0] w_aw_addr_arr;
  logic [NUM_MST-1:0][DATA_W-1:0] w_w_data_arr;
  logic [NUM_MST-1:0][STRB_W-1:0] w_w_strb_arr;

  assign w_ar_addr_arr = slv_ar_addr_i;
  assign w_aw_addr_arr = slv_aw_addr_i;
  assign w_w_data_arr  = slv_w_data_i;
  assign w_w_strb_arr  = slv_w_strb_i;

  // ------------------------------------------------------------------ read
  rd_state_t        r_rd_state, w_rd_state_nxt;
  logic [IDX_W-1:0] r_rd_grant, w_rd_grant_nxt;
  logic [IDX_W-1:0] r_rd_ptr,   w_rd_ptr_nxt;
  logic             w_ar_fwd, w_r_fwd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_state <= R_IDLE;
      r_rd_grant <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_grant <= w_rd_grant_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_grant_nxt = r_rd_grant;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_ar_fwd       = 1'b0;
    w_r_fwd        = 1'b0;
    mst_ar_valid_o = 1'b0;
    mst_r_ready_o  = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (|slv_ar_valid_i) begin
          w_rd_grant_nxt = rr_pick(slv_ar_valid_i, r_rd_ptr);
          w_rd_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        w_ar_fwd       = 1'b1;
        mst_ar_valid_o = slv_ar_valid_i[r_rd_grant];
        if (mst_ar_valid_o && mst_ar_ready_i) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        w_r_fwd       = 1'b1;
        mst_r_ready_o = slv_r_ready_i[r_rd_grant];
        if (mst_r_valid_i && mst_r_ready_o) begin
          w_rd_state_nxt = R_IDLE;
          w_rd_ptr_nxt   = next_idx(r_rd_grant);
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  assign mst_ar_addr_o = w_ar_addr_arr[r_rd_grant];
  assign slv_r_data_o  = mst_r_data_i;
  assign slv_r_resp_o  = mst_r_resp_i;

  // ----------------------------------------------------------------- write
  wr_state_t        r_wr_state, w_wr_state_nxt;
  logic [IDX_W-1:0] r_wr_grant, w_wr_grant_nxt;
  logic [IDX_W-1:0] r_wr_ptr,   w_wr_ptr_nxt;
  logic             r_aw_done,  w_aw_done_nxt;
  logic             r_w_done,   w_w_done_nxt;
  logic             w_aw_fwd, w_w_fwd, w_b_fwd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_state <= W_IDLE;
      r_wr_grant <= '0;
      r_wr_ptr   <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_grant <= w_wr_grant_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_grant_nxt = r_wr_grant;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_aw_fwd       = 1'b0;
    w_w_fwd        = 1'b0;
    w_b_fwd        = 1'b0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    mst_b_ready_o  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        // W alone never starts a grant; AW is the request.
        if (|slv_aw_valid_i) begin
          w_wr_grant_nxt = rr_pick(slv_aw_valid_i, r_wr_ptr);
          w_wr_state_nxt = W_REQ;
        end
      end
      W_REQ: begin
        // AW and W may complete in either order; a finished channel is
        // masked so it cannot handshake twice.
        w_aw_fwd       = !r_aw_done;
        w_w_fwd        = !r_w_done;
        mst_aw_valid_o = slv_aw_valid_i[r_wr_grant] && !r_aw_done;
        mst_w_valid_o  = slv_w_valid_i[r_wr_grant]  && !r_w_done;
        w_aw_done_nxt  = r_aw_done || (mst_aw_valid_o && mst_aw_ready_i);
        w_w_done_nxt   = r_w_done  || (mst_w_valid_o  && mst_w_ready_i);
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_wr_state_nxt = W_RESP;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
        end
      end
      W_RESP: begin
        w_b_fwd       = 1'b1;
        mst_b_ready_o = slv_b_ready_i[r_wr_grant];
        if (mst_b_valid_i && mst_b_ready_o) begin
          w_wr_state_nxt = W_IDLE;
          w_wr_ptr_nxt   = next_idx(r_wr_grant);
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  assign mst_aw_addr_o = w_aw_addr_arr[r_wr_grant];
  assign mst_w_data_o  = w_w_data_arr[r_wr_grant];
  assign mst_w_strb_o  = w_w_strb_arr[r_wr_grant];
  assign slv_b_resp_o  = mst_b_resp_i;

  // ------------------------------------------- per-master ready/valid fanout
  for (genvar k = 0; k < NUM_MST; k++) begin : g_mst
    logic w_sel_rd, w_sel_wr;
    assign w_sel_rd          = (r_rd_grant == IDX_W'(k));
    assign w_sel_wr          = (r_wr_grant == IDX_W'(k));
    assign slv_ar_ready_o[k] = w_ar_fwd && w_sel_rd && mst_ar_ready_i;
    assign slv_r_valid_o[k]  = w_r_fwd  && w_sel_rd && mst_r_valid_i;
    assign slv_aw_ready_o[k] = w_aw_fwd && w_sel_wr && mst_aw_ready_i;
    assign slv_w_ready_o[k]  = w_w_fwd  && w_sel_wr && mst_w_ready_i;
    assign slv_b_valid_o[k]  = w_b_fwd  && w_sel_wr && mst_b_valid_i;
  end

endmodule
